// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: reset vector, sequential
// increment, stall hold, aligned redirect with misalign pulse, halt/resume.
//
// state  | meaning
// IDLE   | out of reset, ce=0; moves to RUN on the first edge
// RUN    | fetching; pc advances, holds on stall or takes a redirect
// HALT   | fetch disabled; debug redirect allowed, resume returns to RUN
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INST_BYTES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  ce,
  output logic                  misalign,
  output logic                  halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // INST_BYTES is a power of two, so INST_BYTES-1 is exactly the alignment mask
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(INST_BYTES);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  ce_q, ce_d;
  logic                  misalign_q, misalign_d;
  logic                  halted_q, halted_d;

  logic [ADDR_WIDTH-1:0] target_aligned;
  logic                  target_misaligned;

  assign target_aligned    = branch_target & ~ALIGN_MASK;
  assign target_misaligned = |(branch_target & ALIGN_MASK);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    misalign_d = 1'b0;
    halted_d   = halted_q;
    case (state_q)
      S_IDLE: begin
        state_d  = S_RUN;
        ce_d     = 1'b1;
        halted_d = 1'b0;
      end
      S_RUN: begin
        if (branch_en) begin
          pc_d       = target_aligned;
          misalign_d = target_misaligned;
        end else if (halt_req) begin
          state_d  = S_HALT;
          ce_d     = 1'b0;
          halted_d = 1'b1;
        end else if (!stall) begin
          pc_d = pc_q + PC_INC;
        end
      end
      S_HALT: begin
        // a redirect wins over resume; resume has to be reasserted afterwards
        if (branch_en) begin
          pc_d       = target_aligned;
          misalign_d = target_misaligned;
        end else if (resume) begin
          state_d  = S_RUN;
          ce_d     = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ce_d     = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      ce_q       <= 1'b0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      misalign_q <= misalign_d;
      halted_q   <= halted_d;
    end
  end

  assign pc       = pc_q;
  assign ce       = ce_q;
  assign misalign = misalign_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit/4-byte instance (reset vector 0x100)
// and a 16-bit/2-byte instance for wrap and narrow-alignment behaviour.
module tb_pc_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, stall, branch_en, halt_req, resume;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        ce, misalign, halted;

  // 16-bit instance
  logic        b_rst, b_stall, b_branch_en, b_halt_req, b_resume;
  logic [15:0] b_branch_target;
  logic [15:0] b_pc;
  logic        b_ce, b_misalign, b_halted;

  int n_cmp = 0;
  int n_err = 0;

  pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h100), .INST_BYTES(4)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
    .branch_target(branch_target), .halt_req(halt_req), .resume(resume),
    .pc(pc), .ce(ce), .misalign(misalign), .halted(halted)
  );

  pc_gen #(.ADDR_WIDTH(16), .RESET_VECTOR(16'h0), .INST_BYTES(2)) dut_b (
    .clk(clk), .rst(b_rst), .stall(b_stall), .branch_en(b_branch_en),
    .branch_target(b_branch_target), .halt_req(b_halt_req), .resume(b_resume),
    .pc(b_pc), .ce(b_ce), .misalign(b_misalign), .halted(b_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] e_pc, input logic e_ce,
                       input logic e_mis, input logic e_halt);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".ce"}, {31'd0, ce}, {31'd0, e_ce});
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
  endtask

  task automatic chk_b(input string tag, input logic [15:0] e_pc, input logic e_ce,
                       input logic e_mis);
    chk({tag, ".pc"}, {16'd0, b_pc}, {16'd0, e_pc});
    chk({tag, ".ce"}, {31'd0, b_ce}, {31'd0, e_ce});
    chk({tag, ".misalign"}, {31'd0, b_misalign}, {31'd0, e_mis});
  endtask

  // outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; halt_req = 1'b0; resume = 1'b0;
    branch_target = '0;
    b_rst = 1'b1; b_stall = 1'b0; b_branch_en = 1'b0; b_halt_req = 1'b0;
    b_resume = 1'b0; b_branch_target = '0;

    step(); step();
    chk_a("reset", 32'h100, 1'b0, 1'b0, 1'b0);
    chk_b("b_reset", 16'h0, 1'b0, 1'b0);
    rst = 1'b0; b_rst = 1'b0;
    chk_a("idle_pre", 32'h100, 1'b0, 1'b0, 1'b0);

    step(); chk_a("run0", 32'h100, 1'b1, 1'b0, 1'b0);
    chk_b("b_run0", 16'h0, 1'b1, 1'b0);
    b_branch_en = 1'b1; b_branch_target = 16'hFFFE;
    step(); chk_a("run1", 32'h104, 1'b1, 1'b0, 1'b0);
    chk_b("b_top", 16'hFFFE, 1'b1, 1'b0);
    b_branch_en = 1'b0;
    step(); chk_a("run2", 32'h108, 1'b1, 1'b0, 1'b0);
    chk_b("b_wrap", 16'h0000, 1'b1, 1'b0);
    b_branch_en = 1'b1; b_branch_target = 16'h1235;
    step(); chk_a("run3", 32'h10C, 1'b1, 1'b0, 1'b0);
    chk_b("b_misal", 16'h1234, 1'b1, 1'b1);
    b_branch_en = 1'b0;

    stall = 1'b1;
    step(); chk_a("stall1", 32'h10C, 1'b1, 1'b0, 1'b0);
    chk_b("b_after", 16'h1236, 1'b1, 1'b0);
    step(); chk_a("stall2", 32'h10C, 1'b1, 1'b0, 1'b0);
    step(); chk_a("stall3", 32'h10C, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk_a("unstall", 32'h110, 1'b1, 1'b0, 1'b0);

    stall = 1'b1; branch_en = 1'b1; branch_target = 32'h200;
    step(); chk_a("br_over_stall", 32'h200, 1'b1, 1'b0, 1'b0);
    stall = 1'b0; branch_en = 1'b0;
    step(); chk_a("after_br", 32'h204, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; branch_target = 32'h206;
    step(); chk_a("misal_br", 32'h204, 1'b1, 1'b1, 1'b0);
    branch_en = 1'b0;
    step(); chk_a("misal_clr", 32'h208, 1'b1, 1'b0, 1'b0);
    branch_en = 1'b1; branch_target = 32'h208;
    step(); chk_a("aligned_br", 32'h208, 1'b1, 1'b0, 1'b0);
    branch_en = 1'b0;
    step(); chk_a("aligned_next", 32'h20C, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; halt_req = 1'b1; branch_target = 32'h118;
    step(); chk_a("br_over_halt", 32'h118, 1'b1, 1'b0, 1'b0);
    branch_en = 1'b0; halt_req = 1'b0;
    step(); chk_a("seq_11c", 32'h11C, 1'b1, 1'b0, 1'b0);
    step(); chk_a("seq_120", 32'h120, 1'b1, 1'b0, 1'b0);

    halt_req = 1'b1;
    step(); chk_a("halt", 32'h120, 1'b0, 1'b0, 1'b1);
    stall = 1'b1;
    step(); chk_a("halt_hold", 32'h120, 1'b0, 1'b0, 1'b1);
    halt_req = 1'b0; stall = 1'b0;
    branch_en = 1'b1; branch_target = 32'h40;
    step(); chk_a("halt_br", 32'h40, 1'b0, 1'b0, 1'b1);
    branch_target = 32'h43; resume = 1'b1;
    step(); chk_a("halt_br_resume", 32'h40, 1'b0, 1'b1, 1'b1);
    branch_en = 1'b0; resume = 1'b0;
    step(); chk_a("halt_still", 32'h40, 1'b0, 1'b0, 1'b1);
    resume = 1'b1;
    step(); chk_a("resume", 32'h40, 1'b1, 1'b0, 1'b0);
    resume = 1'b0;
    step(); chk_a("resume_44", 32'h44, 1'b1, 1'b0, 1'b0);
    step(); chk_a("resume_48", 32'h48, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; branch_target = 32'h14C;
    step(); chk_a("to_14c", 32'h14C, 1'b1, 1'b0, 1'b0);
    branch_en = 1'b0;
    step(); chk_a("at_150", 32'h150, 1'b1, 1'b0, 1'b0);

    #2 rst = 1'b1;
    #1 chk_a("async_rst", 32'h100, 1'b0, 1'b0, 1'b0);
    step(); chk_a("rst_held", 32'h100, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk_a("re_idle", 32'h100, 1'b0, 1'b0, 1'b0);
    step(); chk_a("re_run0", 32'h100, 1'b1, 1'b0, 1'b0);
    step(); chk_a("re_run1", 32'h104, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the IF stage. Successor to the fixed 32-bit, always-increment PC register.
- Adds: configurable width, reset vector and instruction size; stall hold; branch/jump redirect with alignment check; halt/resume control.
- Drives instruction-ROM address (pc) and fetch enable (ce). Redirect, stall and halt come from ID/EX and the debug/control block.

Parameters:
- ADDR_WIDTH, 32, width of pc and branch_target in bits.
- RESET_VECTOR, 0, pc value loaded on reset (ADDR_WIDTH bits, must be aligned to INST_BYTES).
- INST_BYTES, 4, sequential increment in bytes. Power of two, 1..8. Alignment mask is log2(INST_BYTES) low bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- stall  input  1  hold pc this cycle.
- branch_en  input  1  redirect request.
- branch_target  input  ADDR_WIDTH  redirect address.
- halt_req  input  1  enter HALT.
- resume  input  1  leave HALT.
- pc  output  ADDR_WIDTH  current fetch address (registered).
- ce  output  1  fetch enable (registered); ROM is read only when ce=1.
- misalign  output  1  one-cycle pulse: the accepted redirect target was misaligned.
- halted  output  1  high while in HALT (registered).

Behaviour:
- Interface decided: one clock, clk. Reset rst is asynchronous and active-high.

Reset (async, takes effect immediately):
- pc=RESET_VECTOR, ce=0, misalign=0, halted=0, state=IDLE.

IDLE:
- First clock edge after rst deasserts -> RUN, ce<=1, pc unchanged.
- The first fetch is therefore at RESET_VECTOR.
- Inputs are ignored in IDLE.

RUN (ce=1), priority per edge, highest first:
1. branch_en=1:
   - pc <= branch_target with the low log2(INST_BYTES) bits forced to 0.
   - misalign <= 1 if any of those bits was nonzero, else 0.
   - Overrides stall and halt_req in the same cycle; state stays RUN.
2. halt_req=1:
   - -> HALT, ce<=0, halted<=1, pc held.
3. stall=1:
   - pc held, ce stays 1.
4. Otherwise:
   - pc <= pc + INST_BYTES, modulo 2^ADDR_WIDTH. All-ones region wraps to 0; no carry out, no flag.

HALT (ce=0, halted=1):
- branch_en=1: pc loaded as in RUN (same masking and misalign pulse); state stays HALT. This is the debug redirect path.
- resume=1 (and branch_en=0): -> RUN, ce<=1, halted<=0, pc held. The first fetch after resume is at the held pc.
- branch_en=1 and resume=1 together: the load happens and state stays HALT; resume must be reasserted.
- stall and halt_req are ignored in HALT.

General rules:
- misalign is 0 in every cycle not directly following an accepted redirect.
- Latency: every control input affects pc/ce on the next rising edge. No combinational path from inputs to outputs.
- Reset asserted mid-operation (any state, any input): outputs return to their reset values immediately. IDLE sequence restarts after deassertion.
- Invalid state encoding recovers to IDLE.

Test Plan:
- Reset/start (ADDR_WIDTH=32, RESET_VECTOR=0x100, INST_BYTES=4): deassert rst, no inputs -> ce=0 with pc=0x100 for 1 cycle, then ce=1 with pc=0x100,0x104,0x108,...
- Stall and branch priority:
  - stall high 3 cycles at pc=0x10C -> pc holds 0x10C for 3 cycles, ce=1, then 0x110.
  - stall=1 with branch_en=1, target 0x200 -> next pc=0x200.
- Misaligned redirect: branch_target=0x206 -> pc=0x204, misalign=1 for exactly one cycle. Target 0x208 -> misalign stays 0.
- Halt/resume:
  - halt_req at pc=0x120 -> ce=0, halted=1, pc frozen at 0x120.
  - branch_en, target 0x40, while halted -> pc=0x40, still halted.
  - resume -> ce=1, pc=0x40, then 0x44.
- Wrap and width (ADDR_WIDTH=16, INST_BYTES=2): redirect to 0xFFFE -> next pc=0x0000.
- Async reset mid-run: assert rst between edges while at pc=0x150 -> pc=RESET_VECTOR and ce=0 before the next edge; normal IDLE/RUN restart after deassertion.
